// File: rtl/alu_seq.sv
// Purpose: sequential ALU with registered result/flags; optional shift-add multiplier (macro ALU_SEQ_MUL_EN).
// Latency: 1 cycle accept->out_valid for single-cycle ops, WIDTH+1 cycles for MUL when enabled.
// Backpressure: result held in DONE until out_valid & out_ready; in_ready is high only in IDLE.
//
// Ports: clk, rst (async, active-high); in_valid/in_ready request handshake carrying a, b, opcode;
//        out_valid/out_ready result handshake carrying result, zero, carry, negative, overflow;
//        busy is high while the multiplier iterates (tied low when ALU_SEQ_MUL_EN is undefined).
// Opcodes: 000 and, 001 or, 010 add, 011 sub, 100 not a, 101 xor, 110 mul (or zero), 111 zero.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
        EXEC = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept;

    // in_ready is masked by rst so it drops the moment reset asserts.
    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    assign sum  = {1'b0, a} + {1'b0, b};
    // Top bit of the extended difference is the borrow, i.e. a < b unsigned.
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opcode)
            3'b000: alu_res = a & b;
            3'b001: alu_res = a | b;
            3'b010: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'b011: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            3'b100: alu_res = ~a;
            3'b101: alu_res = a ^ b;
            // 110 without the multiplier and 111 both produce zero; with the
            // multiplier this zero only sits in the register during EXEC.
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // ---------------- shift-add multiplier ----------------
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc_nxt;
    logic               last;

    assign last    = (cnt == CW'(WIDTH - 1));
    assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
    assign busy    = (state == EXEC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (accept && (opcode == 3'b110)) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (state == EXEC) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= last ? '0 : cnt + 1'b1;
        end
    end
`else
    assign busy = 1'b0;
`endif

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    state_nxt = (opcode == 3'b110) ? EXEC : DONE;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            EXEC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- result / flag registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                result   <= alu_res;
                zero     <= (alu_res == '0);
                carry    <= alu_c;
                negative <= alu_res[WIDTH-1];
                overflow <= alu_v;
            end
`ifdef ALU_SEQ_MUL_EN
            if ((state == EXEC) && last) begin
                result   <= acc_nxt[WIDTH-1:0];
                zero     <= (acc_nxt[WIDTH-1:0] == '0);
                negative <= acc_nxt[WIDTH-1];
                carry    <= |acc_nxt[2*WIDTH-1:WIDTH];
                overflow <= |acc_nxt[2*WIDTH-1:WIDTH];
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Purpose: self-checking bench for alu_seq at WIDTH=8 using directed vector tables and sequences.
// Latency: measures accept->out_valid edges for every vector.
// Backpressure: exercises out_ready stall with ignored in_valid pulses and reset mid-operation.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] opcode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       negative;
    logic       overflow;
    logic       busy;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .negative  (negative),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // {result, zero, carry, negative, overflow}
    logic [11:0] obs;
    assign obs = {result, zero, carry, negative, overflow};

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one request (called #1 after a rising edge), returns edges until
    // out_valid (accept edge counts as 1) and number of sampled busy cycles.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop,
                          output int lat, output int bcnt);
        a        = ia;
        b        = ib;
        opcode   = iop;
        in_valid = 1'b1;
        #1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        opcode   = 3'($urandom);
        lat      = 1;
        bcnt     = 0;
        while (!out_valid && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       n;
        logic       v;
        int         lat;
        int         bsy;
        string      name;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int bcnt;
        logic [11:0] held;

        //            a      b      op      res    z     c     n     v    lat bsy name
        vecs[0]  = '{8'hFF, 8'h01, 3'b010, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, "add_ff_01"};
        vecs[1]  = '{8'h80, 8'h01, 3'b011, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, "sub_80_01"};
        vecs[2]  = '{8'h01, 8'h02, 3'b011, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, "sub_01_02"};
        vecs[3]  = '{8'hF0, 8'h3C, 3'b000, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, "and"};
        vecs[4]  = '{8'h0F, 8'h80, 3'b001, 8'h8F, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, "or"};
        vecs[5]  = '{8'h7F, 8'h01, 3'b010, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, "add_7f_01"};
        vecs[6]  = '{8'hFF, 8'h12, 3'b100, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, "not_ff"};
        vecs[7]  = '{8'hA5, 8'h5A, 3'b101, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, "xor"};
        vecs[8]  = '{8'h12, 8'h34, 3'b111, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, "op111"};
        vecs[9]  = '{8'h80, 8'h80, 3'b010, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0, "add_80_80"};
        vecs[10] = '{8'h05, 8'h05, 3'b011, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, "sub_05_05"};
`ifdef ALU_SEQ_MUL_EN
        vecs[11] = '{8'h10, 8'h11, 3'b110, 8'h10, 1'b0, 1'b1, 1'b0, 1'b1, 9, 8, "mul_10_11"};
        vecs[12] = '{8'h03, 8'h05, 3'b110, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 9, 8, "mul_03_05"};
`else
        vecs[11] = '{8'h10, 8'h11, 3'b110, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, "mul_10_11_off"};
        vecs[12] = '{8'h03, 8'h05, 3'b110, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, "mul_03_05_off"};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        opcode    = 3'b000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_obs", 32'(obs), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;

        // Vector table; the first accept lands on the first edge with rst low.
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, lat, bcnt);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
            check({vecs[i].name, "_busy"}, 32'(bcnt), 32'(vecs[i].bsy));
            check({vecs[i].name, "_out"}, 32'(obs),
                  32'({vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].n, vecs[i].v}));
            release_out();
            check({vecs[i].name, "_release"}, 32'(out_valid), 32'd0);
        end

        // Stall: out_ready low for 5 cycles with in_valid pulses that must be ignored.
        run_op(8'h02, 8'h03, 3'b010, lat, bcnt);
        check("stall_out", 32'(obs), 32'({8'h05, 1'b0, 1'b0, 1'b0, 1'b0}));
        held = obs;
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            a        = 8'($urandom);
            b        = 8'($urandom);
            opcode   = 3'b010;
            @(posedge clk);
            #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_hold", 32'(obs), 32'(held));
        end
        in_valid = 1'b0;
        release_out();
        check("stall_release_valid", 32'(out_valid), 32'd0);
        check("stall_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("stall_no_ghost", 32'(out_valid), 32'd0);

        // Reset four cycles into a MUL.
        a        = 8'h10;
        b        = 8'h11;
        opcode   = 3'b110;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`ifdef ALU_SEQ_MUL_EN
        check("mid_mul_busy", 32'(busy), 32'd1);
        check("mid_mul_no_valid", 32'(out_valid), 32'd0);
`endif
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_obs", 32'(obs), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op(8'h02, 8'h03, 3'b010, lat, bcnt);
        check("post_rst_lat", 32'(lat), 32'd1);
        check("post_rst_out", 32'(obs), 32'({8'h05, 1'b0, 1'b0, 1'b0, 1'b0}));
        release_out();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
